// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter, the shared combinational ALU and the response consumer.
// The slave modport is the arbiter's view; master is everything around it.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_cmd;
  logic [31:0] req0_src1;
  logic [31:0] req0_src2;
  logic        req0_s;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_cmd;
  logic [31:0] req1_src1;
  logic [31:0] req1_src2;
  logic        req1_s;

  logic [3:0]  alu_cmd;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic        alu_carry;
  logic [31:0] alu_out;
  logic [3:0]  alu_status;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_status;
  logic        rsp_err;

  logic [3:0]  status_reg;

  modport slave (
    input  req0_valid, req0_cmd, req0_src1, req0_src2, req0_s,
    output req0_ready,
    input  req1_valid, req1_cmd, req1_src1, req1_src2, req1_s,
    output req1_ready,
    output alu_cmd, alu_src1, alu_src2, alu_carry,
    input  alu_out, alu_status,
    output rsp_valid, rsp_id, rsp_data, rsp_status, rsp_err,
    input  rsp_ready,
    output status_reg
  );

  modport master (
    output req0_valid, req0_cmd, req0_src1, req0_src2, req0_s,
    input  req0_ready,
    output req1_valid, req1_cmd, req1_src1, req1_src2, req1_s,
    input  req1_ready,
    input  alu_cmd, alu_src1, alu_src2, alu_carry,
    output alu_out, alu_status,
    input  rsp_valid, rsp_id, rsp_data, rsp_status, rsp_err,
    output rsp_ready,
    input  status_reg
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_arbiter (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int ST_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic                       ptr;
  logic                       grant;
  logic                       accept;
  logic                       cmd_legal;

  logic        [CMD_W-1:0]    cmd_p0;
  logic signed [DATA_W-1:0]   src1_p0;
  logic signed [DATA_W-1:0]   src2_p0;
  logic                       s_p0;
  logic                       id_p0;

  logic                       rsp_id_p1;
  logic signed [DATA_W-1:0]   rsp_data_p1;
  logic        [ST_W-1:0]     rsp_status_p1;
  logic                       rsp_err_p1;
  logic        [ST_W-1:0]     flags;

  function automatic logic is_logic_op(input logic [CMD_W-1:0] c);
    return (c == 4'b0001) || (c == 4'b1001) || (c == 4'b0110) ||
           (c == 4'b0111) || (c == 4'b1000);
  endfunction

  function automatic logic is_arith_op(input logic [CMD_W-1:0] c);
    return (c == 4'b0010) || (c == 4'b0011) || (c == 4'b0100) || (c == 4'b0101);
  endfunction

  // Flag order {V,N,C,Z}; logic ops only own Z and N, so C and V survive them.
  function automatic logic [ST_W-1:0] next_flags(input logic [CMD_W-1:0] c,
                                                 input logic            s,
                                                 input logic [ST_W-1:0] cur,
                                                 input logic [ST_W-1:0] alu);
    if (!s)                 return cur;
    else if (is_arith_op(c)) return alu;
    else if (is_logic_op(c)) return {cur[3], alu[2], cur[1], alu[0]};
    else                    return cur;
  endfunction

  // Sole valid requester wins; a tie goes to the round-robin pointer.
  always_comb begin
    grant = ptr;
    if (bus.req0_valid && !bus.req1_valid)
      grant = 1'b0;
    else if (!bus.req0_valid && bus.req1_valid)
      grant = 1'b1;
  end

  assign accept    = rst && (state == IDLE) &&
                     (grant ? bus.req1_valid : bus.req0_valid);
  assign cmd_legal = is_logic_op(cmd_p0) || is_arith_op(cmd_p0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = EXEC;
      EXEC:                       state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_cmd    = '0;
    bus.alu_src1   = '0;
    bus.alu_src2   = '0;
    bus.alu_carry  = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = rst && !grant;
        bus.req1_ready = rst && grant;
      end
      EXEC: begin
        bus.alu_cmd   = cmd_p0;
        bus.alu_src1  = src1_p0;
        bus.alu_src2  = src2_p0;
        bus.alu_carry = flags[1];
      end
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // p0: operation latched on accept; payload is only ever read in EXEC, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_p0  <= grant ? bus.req1_cmd  : bus.req0_cmd;
      src1_p0 <= grant ? bus.req1_src1 : bus.req0_src1;
      src2_p0 <= grant ? bus.req1_src2 : bus.req0_src2;
      s_p0    <= grant ? bus.req1_s    : bus.req0_s;
      id_p0   <= grant;
    end
  end

  // p1: ALU result captured at the end of EXEC and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= 1'b0;
      flags         <= '0;
      rsp_id_p1     <= 1'b0;
      rsp_data_p1   <= '0;
      rsp_status_p1 <= '0;
      rsp_err_p1    <= 1'b0;
    end else begin
      if (accept)
        ptr <= ~grant;
      if (state == EXEC) begin
        rsp_id_p1     <= id_p0;
        rsp_data_p1   <= bus.alu_out;
        rsp_status_p1 <= bus.alu_status;
        rsp_err_p1    <= !cmd_legal;
        flags         <= next_flags(cmd_p0, s_p0, flags, bus.alu_status);
      end
    end
  end

  assign bus.rsp_id     = rsp_id_p1;
  assign bus.rsp_data   = rsp_data_p1;
  assign bus.rsp_status = rsp_status_p1;
  assign bus.rsp_err    = rsp_err_p1;
  assign bus.status_reg = flags;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU on the shared ALU port.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: logic 0001 AND, 1001 OR, 0110 XOR, 0111 NOT, 1000 MOV; arith 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC.
  logic [32:0] alu_w;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [3:0]  alu_st;
  logic        alu_isl;
  logic        alu_isa;
  always_comb begin
    alu_w   = '0;
    alu_b   = bus.alu_src2;
    alu_res = 32'hDEADBEEF;
    alu_st  = 4'b0101;
    alu_isl = 1'b0;
    alu_isa = 1'b0;
    case (bus.alu_cmd)
      4'b0001: begin alu_res = bus.alu_src1 & bus.alu_src2; alu_isl = 1'b1; end
      4'b1001: begin alu_res = bus.alu_src1 | bus.alu_src2; alu_isl = 1'b1; end
      4'b0110: begin alu_res = bus.alu_src1 ^ bus.alu_src2; alu_isl = 1'b1; end
      4'b0111: begin alu_res = ~bus.alu_src1;               alu_isl = 1'b1; end
      4'b1000: begin alu_res = bus.alu_src2;                alu_isl = 1'b1; end
      4'b0010: begin alu_w = {1'b0, bus.alu_src1} + {1'b0, alu_b}; alu_isa = 1'b1; end
      4'b0011: begin alu_w = {1'b0, bus.alu_src1} + {1'b0, alu_b} + 33'(bus.alu_carry); alu_isa = 1'b1; end
      4'b0100: begin alu_b = ~bus.alu_src2; alu_w = {1'b0, bus.alu_src1} + {1'b0, alu_b} + 33'd1; alu_isa = 1'b1; end
      4'b0101: begin alu_b = ~bus.alu_src2; alu_w = {1'b0, bus.alu_src1} + {1'b0, alu_b} + 33'(bus.alu_carry); alu_isa = 1'b1; end
      default: ;
    endcase
    if (alu_isa) begin
      alu_res = alu_w[31:0];
      alu_st  = {(bus.alu_src1[31] == alu_b[31]) && (alu_res[31] != bus.alu_src1[31]),
                 alu_res[31], alu_w[32], alu_res == 32'd0};
    end else if (alu_isl) begin
      alu_st  = {1'b0, alu_res[31], 1'b0, alu_res == 32'd0};
    end
    bus.alu_out    = alu_res;
    bus.alu_status = alu_st;
  end

  logic [3:0]  ex_cmd;
  logic        ex_carry;
  logic        ex_rspv;
  logic        r_valid;
  logic        r_id;
  logic [31:0] r_data;
  logic [3:0]  r_status;
  logic        r_err;
  logic [3:0]  r_sreg;

  // Issue one op from requester id, sample in EXEC and in RESP, return #1 after the edge leaving RESP.
  task automatic run_op(input bit id, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input bit s);
    int n;
    @(negedge clk);
    if (id == 1'b0) begin
      bus.req0_cmd = cmd; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_s = s; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_cmd = cmd; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_s = s; bus.req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d not granted within %0d cycles", id, n);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    ex_cmd = bus.alu_cmd; ex_carry = bus.alu_carry; ex_rspv = bus.rsp_valid;
    @(negedge clk);
    r_valid = bus.rsp_valid; r_id = bus.rsp_id; r_data = bus.rsp_data;
    r_status = bus.rsp_status; r_err = bus.rsp_err; r_sreg = bus.status_reg;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req0_cmd = 4'b0010; bus.req0_src1 = 32'd1; bus.req0_src2 = 32'd1; bus.req0_s = 1'b1;
    bus.req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b expected 0", bus.req1_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.status_reg !== 4'b0000) begin errors++; $display("FAIL rst_status_reg: got %b expected 0000", bus.status_reg); end
    checks++; if (bus.alu_cmd !== 4'b0000) begin errors++; $display("FAIL rst_alu_cmd: got %b expected 0000", bus.alu_cmd); end
    checks++; if ({bus.rsp_id, bus.rsp_data, bus.rsp_status, bus.rsp_err} !== 38'd0) begin errors++; $display("FAIL rst_rsp_fields: got id %b data %h st %b err %b expected all 0", bus.rsp_id, bus.rsp_data, bus.rsp_status, bus.rsp_err); end
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL idle_ready_after_rst: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
  endtask

  task automatic test_back_to_back();
    int g, cyc, last;
    bit gid, hit, prev_id;
    g = 0; cyc = 0; last = 0; prev_id = 1'b0;
    bus.req0_cmd = 4'b0001; bus.req0_src1 = 32'h0000F0F0; bus.req0_src2 = 32'h0000FF00; bus.req0_s = 1'b0;
    bus.req1_cmd = 4'b1001; bus.req1_src1 = 32'h0000F0F0; bus.req1_src2 = 32'h0000FF00; bus.req1_s = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    while (g < 4 && cyc < 40) begin
      #1;
      hit = 1'b0; gid = 1'b0;
      if (bus.req0_ready && bus.req0_valid) begin gid = 1'b0; hit = 1'b1; end
      else if (bus.req1_ready && bus.req1_valid) begin gid = 1'b1; hit = 1'b1; end
      if (bus.rsp_valid) begin
        checks++; if (bus.rsp_id !== prev_id) begin errors++; $display("FAIL b2b_rsp_id: got %b expected %b", bus.rsp_id, prev_id); end
      end
      if (hit) begin
        checks++; if (gid !== g[0]) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", g, gid, g[0]); end
        if (g > 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 3", g, cyc - last); end
        end
        last = cyc; prev_id = gid; g++;
      end
      cyc++;
      if (g < 4) @(negedge clk);
    end
    checks++; if (g != 4) begin errors++; $display("FAIL b2b_grant_count: got %0d expected 4", g); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 32'h0000FFF0}) begin errors++; $display("FAIL b2b_last_rsp: got v %b id %b data %h expected v 1 id 1 data 0000fff0", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    run_op(1'b0, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    checks++; if (ex_cmd !== 4'b0010) begin errors++; $display("FAIL ovf_exec_cmd: got %b expected 0010", ex_cmd); end
    checks++; if (ex_rspv !== 1'b0) begin errors++; $display("FAIL ovf_exec_rsp_valid: got %b expected 0", ex_rspv); end
    checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL ovf_rsp_valid: got %b expected 1", r_valid); end
    checks++; if (r_data !== 32'h80000000) begin errors++; $display("FAIL ovf_data: got %h expected 80000000", r_data); end
    checks++; if (r_id !== 1'b0) begin errors++; $display("FAIL ovf_id: got %b expected 0", r_id); end
    checks++; if (r_status !== 4'b1100) begin errors++; $display("FAIL ovf_rsp_status: got %b expected 1100", r_status); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b expected 0", r_err); end
    checks++; if (r_sreg !== 4'b1100) begin errors++; $display("FAIL ovf_status_reg: got %b expected 1100", r_sreg); end
  endtask

  task automatic test_carry();
    run_op(1'b0, 4'b0010, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    checks++; if (r_sreg !== 4'b0010) begin errors++; $display("FAIL carry_set: got %b expected 0010", r_sreg); end
    run_op(1'b1, 4'b0011, 32'h00000001, 32'h00000001, 1'b1);
    checks++; if (ex_carry !== 1'b1) begin errors++; $display("FAIL adc_alu_carry: got %b expected 1", ex_carry); end
    checks++; if (r_data !== 32'h00000003) begin errors++; $display("FAIL adc_data: got %h expected 00000003", r_data); end
    checks++; if (r_id !== 1'b1) begin errors++; $display("FAIL adc_id: got %b expected 1", r_id); end
    checks++; if (r_sreg !== 4'b0000) begin errors++; $display("FAIL adc_status_reg: got %b expected 0000", r_sreg); end
    run_op(1'b0, 4'b0010, 32'hFFFFFFFF, 32'h00000002, 1'b1);
    run_op(1'b1, 4'b0110, 32'h00000005, 32'h00000005, 1'b1);
    checks++; if (r_data !== 32'h00000000) begin errors++; $display("FAIL xor_zero_data: got %h expected 00000000", r_data); end
    checks++; if (r_sreg !== 4'b0011) begin errors++; $display("FAIL xor_zero_flags: got %b expected 0011", r_sreg); end
    run_op(1'b0, 4'b0010, 32'h80000000, 32'h80000000, 1'b1);
    checks++; if (r_sreg !== 4'b1011) begin errors++; $display("FAIL add_cvz_flags: got %b expected 1011", r_sreg); end
    run_op(1'b1, 4'b0110, 32'h80000000, 32'h00000000, 1'b1);
    checks++; if (r_sreg !== 4'b1110) begin errors++; $display("FAIL xor_neg_keeps_cv: got %b expected 1110", r_sreg); end
  endtask

  task automatic test_err();
    run_op(1'b0, 4'b1111, 32'h00000001, 32'h00000001, 1'b1);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", r_err); end
    checks++; if (r_sreg !== 4'b1110) begin errors++; $display("FAIL illegal_status_reg: got %b expected 1110", r_sreg); end
    run_op(1'b1, 4'b0000, 32'h00000001, 32'h00000001, 1'b1);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL op0000_err: got %b expected 1", r_err); end
    run_op(1'b0, 4'b0010, 32'h00000001, 32'h00000001, 1'b0);
    checks++; if (r_data !== 32'h00000002) begin errors++; $display("FAIL nos_data: got %h expected 00000002", r_data); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL nos_err: got %b expected 0", r_err); end
    checks++; if (r_sreg !== 4'b1110) begin errors++; $display("FAIL nos_status_reg: got %b expected 1110", r_sreg); end
  endtask

  task automatic test_hold();
    bus.rsp_ready = 1'b0;
    run_op(1'b1, 4'b0110, 32'h000000A5, 32'h0000000F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 1'b1, 32'h000000AA, 1'b0}) begin errors++; $display("FAIL hold_rsp%0d: got v %b id %b data %h err %b expected v 1 id 1 data 000000aa err 0", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err); end
      checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready%0d: got %b expected 00", i, {bus.req0_ready, bus.req1_ready}); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL release_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL release_idle_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
  endtask

  task automatic test_reset_exec();
    int n;
    @(negedge clk);
    bus.req0_cmd = 4'b0010; bus.req0_src1 = 32'h7FFFFFFF; bus.req0_src2 = 32'h00000001; bus.req0_s = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req0_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL rexec_accept_timeout: waited %0d cycles", n); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.alu_cmd !== 4'b0010) begin errors++; $display("FAIL rexec_in_exec: got alu_cmd %b expected 0010", bus.alu_cmd); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.alu_cmd, bus.alu_src1, bus.alu_src2, bus.alu_carry} !== 69'd0) begin errors++; $display("FAIL rexec_alu_zero: got cmd %b src1 %h src2 %h carry %b expected all 0", bus.alu_cmd, bus.alu_src1, bus.alu_src2, bus.alu_carry); end
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.status_reg} !== 38'd0) begin errors++; $display("FAIL rexec_outputs_zero: got v %b data %h err %b sreg %b expected all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.status_reg); end
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL rexec_ready_zero: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.status_reg !== 4'b0000) begin errors++; $display("FAIL rexec_status_after_release: got %b expected 0000", bus.status_reg); end
    bus.req0_cmd = 4'b0001; bus.req0_src1 = 32'h0; bus.req0_src2 = 32'h0; bus.req0_s = 1'b0;
    bus.req1_cmd = 4'b1001; bus.req1_src1 = 32'h0; bus.req1_src2 = 32'h0; bus.req1_s = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rexec_first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_id} !== 2'b10) begin errors++; $display("FAIL rexec_first_rsp: got v %b id %b expected v 1 id 0", bus.rsp_valid, bus.rsp_id); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_cmd = '0; bus.req0_src1 = '0; bus.req0_src2 = '0; bus.req0_s = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_cmd = '0; bus.req1_src1 = '0; bus.req1_src2 = '0; bus.req1_s = 1'b0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_carry();
    test_err();
    test_hold();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (data 32, cmd 4, status 4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents an operation.
REQ-005 reqN_ready (N=0,1)  output  1  block accepts requester N's operation this cycle.
REQ-006 reqN_cmd  input  4 / reqN_src1, reqN_src2  input  32 / reqN_s  input  1  opcode, operands, flag-update enable.
REQ-007 alu_cmd  output  4 / alu_src1, alu_src2  output  32 / alu_carry  output  1  drive to the shared combinational ALU.
REQ-008 alu_out  input  32 / alu_status  input  4  ALU result and status, bit0=Z, bit1=C, bit2=N, bit3=V.
REQ-009 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-010 rsp_id  output  1 / rsp_data  output  32 / rsp_status  output  4 / rsp_err  output  1  owner, result, ALU status, illegal-opcode flag.
REQ-011 status_reg  output  4  architectural flags, same bit order as alu_status.

Function
REQ-012 The block SHALL implement FSM states IDLE, EXEC, RESP with one operation in flight at most.
REQ-013 In IDLE, grant SHALL go to the sole valid requester; if both valid, to the requester named by the 1-bit round-robin pointer.
REQ-014 reqN_ready SHALL equal (state==IDLE) AND (grant==N); it is combinational and never asserted outside IDLE.
REQ-015 On accept (valid & ready), cmd/src1/src2/s/id SHALL be latched, the pointer SHALL be set to the non-granted requester, and state SHALL go to EXEC.
REQ-016 In EXEC, alu_cmd/src1/src2 SHALL be driven from latched values; alu_carry SHALL equal status_reg[1]; outside EXEC, alu_* outputs SHALL be 0.
REQ-017 At end of EXEC, alu_out, alu_status, err SHALL be captured into rsp_data, rsp_status, rsp_err; state SHALL go to RESP.
REQ-018 Legal cmds: 0001,1001,0110,0111,1000 (logic), 0010,0011,0100,0101 (arith); all others SHALL set rsp_err=1.
REQ-019 If latched s=1 and cmd legal, status_reg SHALL update at end of EXEC: arith updates all four bits; logic updates Z and N only, C and V retained.
REQ-020 If s=0 or rsp_err=1, status_reg SHALL be unchanged.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_* held stable until rsp_ready=1; on that edge state SHALL return to IDLE.
REQ-022 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-023 Latency: accept at edge T -> rsp_valid high from cycle after edge T+1; minimum 3 cycles per operation with rsp_ready held high.
REQ-024 A request not granted SHALL remain pending with no side effect; requesters keep valid and payload stable until ready.
REQ-025 Operands arriving while not IDLE SHALL NOT be sampled.

Reset
REQ-026 While rst=0: state=IDLE, pointer=0, status_reg=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_status=0, rsp_err=0, reqN_ready=0, alu_*=0.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without any status_reg update.
REQ-028 First grant after reset release SHALL follow REQ-013 with pointer=0.

Verification
REQ-029 req0: cmd=0010, src1=0x7FFFFFFF, src2=1, s=1; ALU model -> rsp_data=0x80000000, rsp_id=0, status_reg=4'b1100 (V,N set) two cycles after accept.
REQ-030 Both valid continuously for 4 ops, rsp_ready=1 -> grants alternate 0,1,0,1; each op 3 cycles apart.
REQ-031 status_reg C=1 then req1 cmd=0011, src1=1, src2=1, s=1 -> alu_carry=1 in EXEC, rsp_data=3; then cmd=0110 with s=1, result 0 -> Z=1, C unchanged 1.
REQ-032 cmd=1111, s=1 -> rsp_err=1, status_reg unchanged; cmd=0010 with s=0 -> status_reg unchanged.
REQ-033 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both reqN_ready=0; release -> IDLE next cycle.
REQ-034 rst=0 mid-EXEC with s=1 -> all outputs 0 immediately, status_reg stays 0 after release, next accepted op from req0.
